// File: rtl/exec_sequencer.sv
// Instruction sequencer: fetch, one/two-phase execute with memory wait, and
// optional interrupt entry (enable with macro SEQ_IRQ_EN).
module exec_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] IRQ_VEC  = 16'h0010
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_data,
  output logic [7:0]  inst,
  output logic        cycle,
  input  logic        MC,
  input  logic        M,
  input  logic        J,
  input  logic        CLI,
  input  logic        dmem_ack,
  input  logic [15:0] jaddr,
  output logic        step,
  input  logic        irq,
  output logic        irq_ack,
  output logic [15:0] epc
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC0 = 2'd1;
  localparam logic [1:0] S_EXEC1 = 2'd2;
  localparam logic [1:0] S_IRQ   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  inst_q, inst_d;
  logic        step_raw, commit, take_irq;

  // EXEC1 with a memory access stalls until dmem_ack; otherwise it steps at once.
  always_comb begin
    step_raw = 1'b0;
    commit   = 1'b0;
    case (state_q)
      S_EXEC0: begin
        step_raw = 1'b1;
        commit   = ~MC;
      end
      S_EXEC1: begin
        step_raw = ~M | dmem_ack;
        commit   = step_raw;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      S_FETCH: if (imem_ack) begin
        inst_d  = imem_data;
        pc_d    = pc_q + 16'd1;
        state_d = S_EXEC0;
      end
      S_EXEC0: begin
        if (MC)          state_d = S_EXEC1;
        else if (take_irq) state_d = S_IRQ;
        else             state_d = S_FETCH;
      end
      S_EXEC1: if (step_raw) begin
        if (J) pc_d = jaddr;
        state_d = take_irq ? S_IRQ : S_FETCH;
      end
      S_IRQ: begin
        pc_d    = IRQ_VEC;
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign imem_req  = (state_q == S_FETCH) & ~rst;
  assign imem_addr = pc_q;
  assign cycle     = (state_q == S_EXEC1) & ~rst;
  assign step      = step_raw & ~rst;
  assign inst      = inst_q;

`ifdef SEQ_IRQ_EN
  logic        ie_q, irq_ack_q;
  logic [15:0] epc_q;

  // Decision uses the ie value before any CLI in the same step lands.
  assign take_irq = commit & irq & ie_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q      <= 1'b1;
      epc_q     <= 16'h0000;
      irq_ack_q <= 1'b0;
    end else begin
      irq_ack_q <= take_irq;
      if (state_q == S_IRQ) begin
        ie_q  <= 1'b0;
        epc_q <= pc_q;
      end else if (step_raw && CLI) begin
        ie_q <= 1'b1;
      end
    end
  end

  assign irq_ack = irq_ack_q & ~rst;
  assign epc     = epc_q;
`else
  logic unused_irq;
  assign unused_irq = ^{irq, CLI, commit};
  assign take_irq   = 1'b0;
  assign irq_ack    = 1'b0;
  assign epc        = 16'h0000;
`endif

endmodule
